data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter D_ADDR_W, default 12, data-memory address width.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter WE_CYCLES, default 1, write-enable pulse length in cycles; legal range >=1.
REQ-004 Parameter RD_CYCLES, default 1, output-enable cycles before read capture; legal range >=1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  CPU access request valid.
REQ-008 req_ready  output  1  controller can accept a request.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  D_ADDR_W  access address.
REQ-011 req_wdata  input  DATA_W  store data.
REQ-012 rsp_valid  output  1  access complete.
REQ-013 rsp_ready  input  1  CPU accepts the response.
REQ-014 rsp_rdata  output  DATA_W  load result; holds the last load value after stores.
REQ-015 mem_addr  output  D_ADDR_W  to memory data_addr.
REQ-016 mem_wdata  output  DATA_W  to memory write_data.
REQ-017 mem_we  output  1  to memory write_enable.
REQ-018 mem_oe  output  1  to memory output_enable.
REQ-019 mem_rdata  input  DATA_W  from memory read_data; high-Z unless mem_oe=1 and mem_we=0.

Function
REQ-020 FSM states: IDLE, SETUP, STROBE, HOLD, READ, RESP; one request outstanding at most.
REQ-021 IDLE: req_ready=1, mem_we=0, mem_oe=0; req_valid=1 latches addr/wdata/write into registers and moves to SETUP.
REQ-022 req_ready=0 in every state except IDLE.
REQ-023 mem_addr and mem_wdata are driven only from the latched registers, stay stable from SETUP through RESP, and keep their values in IDLE.
REQ-024 SETUP: exactly 1 cycle with mem_we=0 and mem_oe=0; goes to STROBE for a store and to READ for a load.
REQ-025 STROBE: mem_we=1 and mem_oe=0 for exactly WE_CYCLES cycles, timed by a down-counter, then HOLD.
REQ-026 HOLD: exactly 1 cycle with mem_we=0 and address/data unchanged, then RESP.
REQ-027 READ: mem_oe=1 and mem_we=0 for exactly RD_CYCLES cycles; mem_rdata is registered into rsp_rdata on the last READ edge, then RESP.
REQ-028 mem_we and mem_oe are never 1 in the same cycle; both come directly from registers (glitch-free).
REQ-029 RESP: rsp_valid=1 until rsp_ready=1, then IDLE; RESP lasts 1 cycle if rsp_ready is already high.
REQ-030 Latency with defaults: store accepted at cycle 0 gives rsp_valid at cycle 4; load gives rsp_valid at cycle 3.
REQ-031 rsp_rdata changes only on the capture edge of a load.
REQ-032 A request at address 2^D_ADDR_W-1 is passed through unchanged; the controller does no address arithmetic.

Reset
REQ-033 rst_n=0 forces, immediately and asynchronously: state IDLE, mem_we=0, mem_oe=0, rsp_valid=0, mem_addr=0, mem_wdata=0, rsp_rdata=0, counter=0.
REQ-034 req_ready=1 in the first cycle after rst_n deasserts.
REQ-035 A reset in the middle of an access abandons it with no response; a reset during STROBE may leave that location partially written.

Structure
REQ-036 Package data_mem_ctrl_pkg holds the state enum and the default widths D_ADDR_W=12 and DATA_W=8.
REQ-037 No sub-module; the cycle counter is inline, sized to $clog2(max(WE_CYCLES,RD_CYCLES)+1).

Verification
REQ-038 Store 0xA5 to 0x123 with rsp_ready=1: mem_we is high for exactly cycle 2, mem_addr=0x123 during cycles 1-3, and rsp_valid is seen at cycle 4.
REQ-039 Load 0x123 after that store: mem_oe is high for cycle 2 only, and rsp_rdata=0xA5 with rsp_valid at cycle 3.
REQ-040 Hold rsp_ready=0 for 5 cycles after a load: rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a held req_valid is not accepted.
REQ-041 Assert rst_n=0 during STROBE: mem_we drops with no clock edge, and no rsp_valid follows.
REQ-042 Set WE_CYCLES=3 and RD_CYCLES=2 and run a store/load at 0xFFF: the pulse widths are 3 and 2 cycles, the data round-trips, and an assertion confirms mem_we and mem_oe are never high together.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and default widths for the data-memory controller.
// The state enum is shared so other blocks can decode controller state.
package data_mem_ctrl_pkg;

  localparam int DEF_D_ADDR_W = 12;
  localparam int DEF_DATA_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    READ,
    RESP
  } state_t;

endpackage

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data-memory controller with a strobed SRAM-style port.
// mem_we/mem_oe are registered so the memory never sees a glitch or overlap.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int D_ADDR_W  = DEF_D_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WE_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [D_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_oe,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MAX_C = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             write_q;
  logic             accept;
  logic             capture;
  logic             last;
  logic             we_n;
  logic             oe_n;
  logic             rv_n;

  assign last      = (cnt == '0);
  assign req_ready = (state == IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_n = SETUP;
          accept  = 1'b1;
        end
      end
      SETUP: begin
        if (write_q) begin
          state_n = STROBE;
          cnt_n   = WE_LOAD;
        end else begin
          state_n = READ;
          cnt_n   = RD_LOAD;
        end
      end
      STROBE: begin
        if (last) state_n = HOLD;
        else      cnt_n   = cnt - ONE;
      end
      HOLD: state_n = RESP;
      READ: begin
        if (last) begin
          state_n = RESP;
          capture = 1'b1;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Strobes are decoded from the next state and then registered.
    we_n = (state_n == STROBE);
    oe_n = (state_n == READ);
    rv_n = (state_n == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_we    <= we_n;
      mem_oe    <= oe_n;
      rsp_valid <= rv_n;
      if (accept) begin
        write_q   <= req_write;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      if (capture) rsp_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: default and stretched-strobe
// instances against a behavioural memory and latency model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        rr1, rv1, we1, oe1, rr2, rv2, we2, oe2;
  logic [7:0]  rd1, wd1, mr1, rd2, wd2, mr2;
  logic [11:0] ma1, ma2;

  logic        o_rr, o_rv, o_we, o_oe;
  logic [7:0]  o_rd, o_wd;
  logic [11:0] o_ma;

  int vectors = 0;
  int errors = 0;

  logic [7:0]  mem1 [4096];
  logic [7:0]  mem2 [4096];
  logic [7:0]  ref1 [logic [11:0]];
  logic [7:0]  ref2 [logic [11:0]];
  logic [11:0] keys1 [$];
  logic [7:0]  last_load [2];

  always #5 clk = ~clk;

  data_mem_ctrl dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1),
    .mem_addr(ma1), .mem_wdata(wd1), .mem_we(we1), .mem_oe(oe1),
    .mem_rdata(mr1)
  );

  data_mem_ctrl #(.WE_CYCLES(3), .RD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(rr2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2),
    .mem_addr(ma2), .mem_wdata(wd2), .mem_we(we2), .mem_oe(oe2),
    .mem_rdata(mr2)
  );

  always @(posedge clk) begin
    if (we1) mem1[ma1] <= wd1;
    if (we2) mem2[ma2] <= wd2;
  end

  assign mr1 = (oe1 && !we1) ? mem1[ma1] : 8'h00;
  assign mr2 = (oe2 && !we2) ? mem2[ma2] : 8'h00;

  assign o_rr = sel ? rr2 : rr1;
  assign o_rv = sel ? rv2 : rv1;
  assign o_we = sel ? we2 : we1;
  assign o_oe = sel ? oe2 : oe1;
  assign o_rd = sel ? rd2 : rd1;
  assign o_wd = sel ? wd2 : wd1;
  assign o_ma = sel ? ma2 : ma1;

  always @(negedge clk) begin
    assert (!(we1 && oe1) && !(we2 && oe2)) else begin
      errors++;
      $display("FAIL we_oe_excl we1=%0b oe1=%0b we2=%0b oe2=%0b", we1, oe1, we2, oe2);
    end
  end

  task automatic access(input bit w, input logic [11:0] a,
                        input logic [7:0] d, input bit rdy,
                        output int lat, output int wew, output int oew,
                        output int we_at, output int oe_at, output bit aok);
    @(negedge clk);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    rsp_ready = rdy;
    lat = 0; wew = 0; oew = 0; we_at = 0; oe_at = 0; aok = 1'b1;
    vectors++;
    if (o_rr !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle got=%0b want=1", o_rr);
    end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (o_we) begin wew++; if (we_at == 0) we_at = c; end
      if (o_oe) begin oew++; if (oe_at == 0) oe_at = c; end
      if (o_ma !== a) aok = 1'b0;
      if (w && o_wd !== d) aok = 1'b0;
      if (o_rr !== 1'b0) aok = 1'b0;
      if (o_rv) lat = c;
    end
    vectors++;
    if (lat == 0) begin
      errors++;
      $display("FAIL rsp_timeout addr=%h no rsp_valid within 20 cycles", a);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_rv !== 1'b0 || o_rr !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release rv=%0b rr=%0b want rv=0 rr=1", o_rv, o_rr);
    end
  endtask

  task automatic do_store(input logic [11:0] a, input logic [7:0] d);
    int lat, wew, oew, we_at, oe_at, exp_w;
    bit aok;
    exp_w = sel ? 3 : 1;
    access(1'b1, a, d, 1'b1, lat, wew, oew, we_at, oe_at, aok);
    vectors++;
    if (lat != exp_w + 3) begin
      errors++;
      $display("FAIL store_latency addr=%h got=%0d want=%0d", a, lat, exp_w + 3);
    end
    vectors++;
    if (wew != exp_w || we_at != 2 || oew != 0) begin
      errors++;
      $display("FAIL store_we_pulse got width=%0d start=%0d oe=%0d want width=%0d start=2 oe=0",
               wew, we_at, oew, exp_w);
    end
    vectors++;
    if (!aok) begin
      errors++;
      $display("FAIL store_addr_stable addr=%h got unstable want stable", a);
    end
    vectors++;
    if (o_rd !== last_load[int'(sel)]) begin
      errors++;
      $display("FAIL store_rdata_hold got=%h want=%h", o_rd, last_load[int'(sel)]);
    end
    finish_rsp();
    if (sel) ref2[a] = d;
    else begin
      if (!ref1.exists(a)) keys1.push_back(a);
      ref1[a] = d;
    end
  endtask

  task automatic do_load(input logic [11:0] a, input bit rdy,
                         output logic [7:0] exp_d);
    int lat, wew, oew, we_at, oe_at, exp_r;
    bit aok;
    exp_r = sel ? 2 : 1;
    exp_d = sel ? ref2[a] : ref1[a];
    access(1'b0, a, 8'h00, rdy, lat, wew, oew, we_at, oe_at, aok);
    vectors++;
    if (lat != exp_r + 2) begin
      errors++;
      $display("FAIL load_latency addr=%h got=%0d want=%0d", a, lat, exp_r + 2);
    end
    vectors++;
    if (oew != exp_r || oe_at != 2 || wew != 0) begin
      errors++;
      $display("FAIL load_oe_pulse got width=%0d start=%0d we=%0d want width=%0d start=2 we=0",
               oew, oe_at, wew, exp_r);
    end
    vectors++;
    if (!aok) begin
      errors++;
      $display("FAIL load_addr_stable addr=%h got unstable want stable", a);
    end
    vectors++;
    if (o_rd !== exp_d) begin
      errors++;
      $display("FAIL load_data addr=%h got=%h want=%h", a, o_rd, exp_d);
    end
    last_load[int'(sel)] = exp_d;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({we1, oe1, rv1, we2, oe2, rv2} !== 6'b0 ||
        ma1 !== 12'h0 || wd1 !== 8'h0 || rd1 !== 8'h0 ||
        ma2 !== 12'h0 || wd2 !== 8'h0 || rd2 !== 8'h0) begin
      errors++;
      $display("FAIL reset_values we=%0b oe=%0b rv=%0b addr=%h wd=%h rd=%h want all 0",
               we1, oe1, rv1, ma1, wd1, rd1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (rr1 !== 1'b1 || rr2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%0b%0b want=11", rr1, rr2);
    end
    last_load[0] = 8'h00;
    last_load[1] = 8'h00;
  endtask

  task automatic test_directed();
    logic [7:0] d;
    sel = 1'b0;
    do_store(12'h123, 8'hA5);
    do_load(12'h123, 1'b1, d);
    finish_rsp();
    do_store(12'hFFF, 8'h3C);
    do_load(12'hFFF, 1'b1, d);
    finish_rsp();
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    sel = 1'b0;
    do_load(12'h123, 1'b0, d);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 12'h055;
      @(negedge clk);
      vectors++;
      if (o_rv !== 1'b1 || o_rd !== d || o_rr !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d rv=%0b rd=%h rr=%0b want rv=1 rd=%h rr=0",
                 i, o_rv, o_rd, o_rr, d);
      end
    end
    req_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    vectors++;
    if (o_rv !== 1'b0 || o_we !== 1'b0 || o_ma !== 12'h123) begin
      errors++;
      $display("FAIL held_req_ignored rv=%0b we=%0b addr=%h want rv=0 we=0 addr=123",
               o_rv, o_we, o_ma);
    end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic [11:0] a;
    sel = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0 || keys1.size() == 0) begin
        a = 12'($urandom_range(0, 4095));
        do_store(a, 8'($urandom_range(1, 255)));
      end else begin
        a = keys1[$urandom_range(0, keys1.size() - 1)];
        do_load(a, 1'b1, d);
        finish_rsp();
      end
    end
  endtask

  task automatic test_params();
    logic [7:0] d;
    logic [7:0] wd;
    sel = 1'b1;
    wd = 8'($urandom_range(1, 255));
    do_store(12'hFFF, wd);
    do_load(12'hFFF, 1'b1, d);
    finish_rsp();
    do_store(12'h000, ~wd);
    do_load(12'h000, 1'b1, d);
    finish_rsp();
    sel = 1'b0;
  endtask

  task automatic test_reset_strobe();
    bit seen;
    sel = 1'b0;
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 12'h7AA;
    req_wdata = 8'h5A;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_we !== 1'b1) begin
      errors++;
      $display("FAIL strobe_before_reset we=%0b want=1", o_we);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (o_we !== 1'b0 || o_rv !== 1'b0 || o_rr !== 1'b1) begin
      errors++;
      $display("FAIL async_reset we=%0b rv=%0b rr=%0b want we=0 rv=0 rr=1", o_we, o_rv, o_rr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_rv) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned_no_rsp got rsp_valid=1 want none");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_params();
    test_reset_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
